rw_burst_ctrl: RTL and testbench

Parametrised read/write transaction controller and successor to the single-beat read/write FSM. It accepts a READ or WRITE task from the testbench, then sequences the USB transactions through the protocol FSM:

- one OUT address transaction carrying `mempage`;
- then `burst_len` data transactions: IN for reads, OUT for writes.

It handles per-phase retry, DATA0/DATA1 toggling, bit reversal to wire order, and completion reporting. It sits between the testbench and the protocol FSM.

---
 rtl/usb_pkg.sv | 26 ++
 rtl/bit_reverse.sv | 13 +
 rtl/rw_burst_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rw_burst_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB constants and type definitions for the read/write burst controller.
package usb_pkg;

  // Token and data PIDs
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  typedef enum logic [1:0] {
    TASK_IDLE  = 2'd0,
    TASK_READ  = 2'd1,
    TASK_WRITE = 2'd2,
    TASK_RSVD  = 2'd3
  } task_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_A_ISSUE = 3'd1,
    S_A_WAIT  = 3'd2,
    S_D_ISSUE = 3'd3,
    S_D_WAIT  = 3'd4,
    S_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/bit_reverse.sv
// Purely combinational W-bit reversal: dout[i] = din[W-1-i].
module bit_reverse #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign dout[i] = din[W-1-i];
  end

endmodule

// File: rtl/rw_burst_ctrl.sv
// Read/write burst controller: one OUT address transaction carrying the memory
// page, then burst_len data transactions (IN for reads, OUT for writes), with
// per-phase retry, DATA0/DATA1 toggling and bit reversal to wire order.
module rw_burst_ctrl
  import usb_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter logic [6:0]  DEV_ADDR  = 7'd5,
  parameter logic [3:0]  ADDR_ENDP = 4'd4,
  parameter logic [3:0]  RD_ENDP   = 4'd8,
  parameter int          MAX_RETRY = 3,
  parameter int          BURST_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          task_req,
  input  logic [15:0]         mempage,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_req,
  input  logic                ptcl_ready,
  input  logic                ptcl_done,
  input  logic                ptcl_success,
  input  logic [DATA_W-1:0]   ptcl_rx_data,
  output logic                ptcl_start,
  output logic [18:0]         token_out,
  output logic [DATA_W+7:0]   data_out,
  output logic                data_avail,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic [BURST_W-1:0]  beat_idx,
  output logic                task_done,
  output logic                task_success
);

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_e              state_q, state_d;
  task_e               task_in;
  logic                is_wr_q;
  logic [BURST_W-1:0]  last_idx_q;
  logic [RTY_W-1:0]    retry_q;
  logic                tgl_q;       // 1 = next write beat uses DATA1
  logic                result_q;
  logic [DATA_W-1:0]   payload_q;   // natural order; reversed on the way out
  logic                accept, retry_ok, last_beat, d_phase, a_phase;
  logic [3:0]          endp_sel;
  logic [6:0]          dev_rev;
  logic [3:0]          endp_rev;
  logic [DATA_W-1:0]   tx_rev, rx_rev;

  assign task_in   = task_e'(task_req);
  assign accept    = (state_q == S_IDLE) && (task_in == TASK_READ || task_in == TASK_WRITE);
  assign retry_ok  = retry_q < RTY_W'(MAX_RETRY);
  assign last_beat = beat_idx == last_idx_q;
  assign a_phase   = (state_q == S_A_ISSUE) || (state_q == S_A_WAIT);
  assign d_phase   = (state_q == S_D_ISSUE) || (state_q == S_D_WAIT);
  assign endp_sel  = (d_phase && !is_wr_q) ? RD_ENDP : ADDR_ENDP;

  bit_reverse #(.W(7))      u_rev_addr (.din(DEV_ADDR),     .dout(dev_rev));
  bit_reverse #(.W(4))      u_rev_endp (.din(endp_sel),     .dout(endp_rev));
  bit_reverse #(.W(DATA_W)) u_rev_tx   (.din(payload_q),    .dout(tx_rev));
  bit_reverse #(.W(DATA_W)) u_rev_rx   (.din(ptcl_rx_data), .dout(rx_rev));

  // Next-state and combinational outputs; token/data held from ISSUE through WAIT
  always_comb begin
    state_d      = state_q;
    ptcl_start   = 1'b0;
    token_out    = '0;
    data_out     = '0;
    data_avail   = 1'b0;
    wr_req       = 1'b0;
    task_done    = 1'b0;
    task_success = 1'b0;

    if (a_phase) begin
      token_out  = {PID_OUT, dev_rev, endp_rev};
      data_out   = {PID_DATA0, tx_rev};
      data_avail = 1'b1;
    end else if (d_phase) begin
      if (is_wr_q) begin
        token_out  = {PID_OUT, dev_rev, endp_rev};
        data_out   = {(tgl_q ? PID_DATA1 : PID_DATA0), tx_rev};
        data_avail = 1'b1;
      end else begin
        token_out  = {PID_IN, dev_rev, endp_rev};
      end
    end

    case (state_q)
      S_IDLE: if (accept) state_d = S_A_ISSUE;
      S_A_ISSUE, S_D_ISSUE: begin
        ptcl_start = ptcl_ready;
        if (ptcl_ready) state_d = (state_q == S_A_ISSUE) ? S_A_WAIT : S_D_WAIT;
      end
      S_A_WAIT: if (ptcl_done) begin
        if (ptcl_success) begin
          state_d = S_D_ISSUE;
          wr_req  = is_wr_q;
        end else begin
          state_d = retry_ok ? S_A_ISSUE : S_DONE;
        end
      end
      S_D_WAIT: if (ptcl_done) begin
        if (ptcl_success) begin
          state_d = last_beat ? S_DONE : S_D_ISSUE;
          wr_req  = is_wr_q && !last_beat;
        end else begin
          state_d = retry_ok ? S_D_ISSUE : S_DONE;
        end
      end
      S_DONE: begin
        task_done    = 1'b1;
        task_success = result_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, task context, retry/toggle bookkeeping and read-beat capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      last_idx_q <= '0;
      retry_q    <= '0;
      tgl_q      <= 1'b0;
      result_q   <= 1'b0;
      payload_q  <= '0;
      beat_idx   <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_valid <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          is_wr_q    <= (task_in == TASK_WRITE);
          last_idx_q <= (burst_len == '0) ? '0 : burst_len - BURST_W'(1);
          beat_idx   <= '0;
          retry_q    <= '0;
          tgl_q      <= 1'b0;
          result_q   <= 1'b0;
          payload_q  <= DATA_W'(mempage);
        end
        S_A_WAIT: if (ptcl_done) begin
          if (ptcl_success) begin
            retry_q <= '0;
            tgl_q   <= 1'b1;
            if (is_wr_q) payload_q <= wr_data;
          end else if (retry_ok) begin
            retry_q <= retry_q + RTY_W'(1);
          end else begin
            result_q <= 1'b0;
          end
        end
        S_D_WAIT: if (ptcl_done) begin
          if (ptcl_success) begin
            retry_q <= '0;
            tgl_q   <= ~tgl_q;
            if (!is_wr_q) begin
              rd_data  <= rx_rev;
              rd_valid <= 1'b1;
            end
            if (last_beat) begin
              result_q <= 1'b1;
            end else begin
              beat_idx <= beat_idx + BURST_W'(1);
              if (is_wr_q) payload_q <= wr_data;
            end
          end else if (retry_ok) begin
            retry_q <= retry_q + RTY_W'(1);
          end else begin
            result_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rw_burst_ctrl.sv
// Directed bench for rw_burst_ctrl: acts as the protocol FSM and the task source.
module tb_rw_burst_ctrl;

  localparam int DATA_W  = 64;
  localparam int BURST_W = 3;

  // Hand-computed wire-order tokens: rev7(5) = 1010000, rev4(4) = 0010, rev4(8) = 0001
  localparam logic [18:0] TOK_OUT = {8'hE1, 7'b1010000, 4'b0010};
  localparam logic [18:0] TOK_IN  = {8'h69, 7'b1010000, 4'b0001};

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          task_req;
  logic [15:0]         mempage;
  logic [BURST_W-1:0]  burst_len;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_req;
  logic                ptcl_ready, ptcl_done, ptcl_success;
  logic [DATA_W-1:0]   ptcl_rx_data;
  logic                ptcl_start;
  logic [18:0]         token_out;
  logic [DATA_W+7:0]   data_out;
  logic                data_avail;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic [BURST_W-1:0]  beat_idx;
  logic                task_done, task_success;

  int passed = 0;
  int failed = 0;
  int starts = 0;
  int dones  = 0;

  rw_burst_ctrl dut (
    .clk(clk), .rst(rst), .task_req(task_req), .mempage(mempage),
    .burst_len(burst_len), .wr_data(wr_data), .wr_req(wr_req),
    .ptcl_ready(ptcl_ready), .ptcl_done(ptcl_done), .ptcl_success(ptcl_success),
    .ptcl_rx_data(ptcl_rx_data), .ptcl_start(ptcl_start), .token_out(token_out),
    .data_out(data_out), .data_avail(data_avail), .rd_data(rd_data),
    .rd_valid(rd_valid), .beat_idx(beat_idx), .task_done(task_done),
    .task_success(task_success)
  );

  always #5 clk = ~clk;

  // Count start and completion pulses
  always @(posedge clk) begin
    if (ptcl_start) starts <= starts + 1;
    if (task_done)  dones  <= dones + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_task(input logic [1:0] t, input logic [15:0] pg, input logic [BURST_W-1:0] bl);
    @(negedge clk);
    task_req = t; mempage = pg; burst_len = bl;
    @(posedge clk); #1;
    task_req = 2'd0; mempage = 16'hFFFF; burst_len = '1;
  endtask

  // One cycle in an ISSUE state: start must fire; capture what is offered
  task automatic issue(input string tag, output logic [18:0] tok, output logic [DATA_W+7:0] dat,
                       output logic [BURST_W-1:0] bi);
    @(negedge clk);
    chk({tag, "_start"}, ptcl_start, 1'b1);
    tok = token_out; dat = data_out; bi = beat_idx;
  endtask

  // The WAIT cycle: complete the transaction with the given result
  task automatic finish_ph(input logic ok, input logic [DATA_W-1:0] rx, output logic wrq);
    @(negedge clk);
    ptcl_done = 1'b1; ptcl_success = ok; ptcl_rx_data = rx;
    #1 wrq = wr_req;
    @(posedge clk); #1;
    ptcl_done = 1'b0; ptcl_success = 1'b0; ptcl_rx_data = '0;
  endtask

  logic [18:0]        tok;
  logic [DATA_W+7:0]  dat;
  logic [BURST_W-1:0] bi;
  logic               wrq;
  int                 s0, d0;
  logic [DATA_W-1:0]  rx_tab  [3] = '{64'h5000_0000_0000_0000, 64'hD000_0000_0000_0000, 64'h3000_0000_0000_0000};
  logic [DATA_W-1:0]  rd_tab  [3] = '{64'hA, 64'hB, 64'hC};
  logic [DATA_W+7:0]  w4_tab  [4] = '{{8'h4B, 64'h8000_0000_0000_0000}, {8'hC3, 64'h4000_0000_0000_0000},
                                     {8'h4B, 64'hC000_0000_0000_0000}, {8'hC3, 64'h2000_0000_0000_0000}};

  initial begin
    rst = 1'b1; task_req = 2'd0; mempage = '0; burst_len = '0; wr_data = '0;
    ptcl_ready = 1'b1; ptcl_done = 1'b0; ptcl_success = 1'b0; ptcl_rx_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {ptcl_start, data_avail, wr_req, rd_valid, task_done, task_success}, 6'b0);
    chk("rst_tok", token_out, 19'd0);
    chk("rst_dat", data_out, 72'd0);
    chk("rst_rd",  {rd_data, beat_idx}, '0);
    rst = 1'b0;

    // 1: single-beat write
    start_task(2'd2, 16'h1234, 3'd1);
    wr_data = 64'h1;
    issue("t1_a", tok, dat, bi);
    chk("t1_a_tok", tok, TOK_OUT);
    chk("t1_a_dat", dat, {8'hC3, 64'h2C48_0000_0000_0000});
    chk("t1_a_avail", data_avail, 1'b1);
    finish_ph(1'b1, '0, wrq);
    chk("t1_a_wrreq", wrq, 1'b1);
    issue("t1_d", tok, dat, bi);
    chk("t1_d_tok", tok, TOK_OUT);
    chk("t1_d_dat", dat, {8'h4B, 64'h8000_0000_0000_0000});
    finish_ph(1'b1, '0, wrq);
    chk("t1_d_wrreq", wrq, 1'b0);
    @(negedge clk);
    chk("t1_done", {task_done, task_success}, 2'b11);
    @(negedge clk);
    chk("t1_done_pulse", task_done, 1'b0);

    // 2: three-beat read
    start_task(2'd1, 16'h0042, 3'd3);
    issue("t2_a", tok, dat, bi);
    chk("t2_a_dat", dat, {8'hC3, 64'h4200_0000_0000_0000});
    finish_ph(1'b1, '0, wrq);
    chk("t2_a_wrreq", wrq, 1'b0);
    for (int b = 0; b < 3; b++) begin
      issue("t2_d", tok, dat, bi);
      chk("t2_in_tok", tok, TOK_IN);
      chk("t2_beat", bi, 3'(b));
      chk("t2_nodata", {data_avail, data_out}, '0);
      finish_ph(1'b1, rx_tab[b], wrq);
      chk("t2_rd", {rd_valid, rd_data}, {1'b1, rd_tab[b]});
    end
    @(negedge clk);
    chk("t2_done", {task_done, task_success}, 2'b11);

    // 3: address fails twice, then succeeds
    s0 = starts;
    start_task(2'd2, 16'h0001, 3'd1);
    for (int r = 0; r < 3; r++) begin
      issue("t3_a", tok, dat, bi);
      chk("t3_a_tok", tok, TOK_OUT);
      chk("t3_a_dat", dat, {8'hC3, 64'h8000_0000_0000_0000});
      wr_data = 64'h5;
      finish_ph(r == 2, '0, wrq);
      chk("t3_a_wrreq", wrq, r == 2);
    end
    issue("t3_d", tok, dat, bi);
    chk("t3_d_dat", dat, {8'h4B, 64'hA000_0000_0000_0000});
    finish_ph(1'b1, '0, wrq);
    @(negedge clk);
    chk("t3_done", {task_done, task_success}, 2'b11);
    chk("t3_starts", starts - s0, 4);

    // 4: data phase fails four times -> failure, no further starts
    start_task(2'd2, 16'h0002, 3'd1);
    wr_data = 64'h7;
    issue("t4_a", tok, dat, bi);
    finish_ph(1'b1, '0, wrq);
    s0 = starts;
    for (int r = 0; r < 4; r++) begin
      issue("t4_d", tok, dat, bi);
      chk("t4_d_dat", dat, {8'h4B, 64'hE000_0000_0000_0000});
      finish_ph(1'b0, '0, wrq);
      chk("t4_wrreq", wrq, 1'b0);
    end
    @(negedge clk);
    chk("t4_done", {task_done, task_success}, 2'b10);
    repeat (3) @(negedge clk);
    chk("t4_starts", starts - s0, 4);

    // 5: reset while in D_WAIT
    start_task(2'd2, 16'h0003, 3'd2);
    wr_data = 64'h9;
    issue("t5_a", tok, dat, bi);
    finish_ph(1'b1, '0, wrq);
    issue("t5_d", tok, dat, bi);
    d0 = dones;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_rst_ctl", {ptcl_start, data_avail, wr_req, rd_valid, task_done, task_success, beat_idx}, '0);
    chk("t5_rst_bus", {token_out, data_out}, '0);
    repeat (3) @(negedge clk);
    chk("t5_no_done", dones - d0, 0);
    start_task(2'd2, 16'h1234, 3'd1);
    wr_data = 64'h1;
    issue("t5b_a", tok, dat, bi);
    chk("t5b_a_dat", dat, {8'hC3, 64'h2C48_0000_0000_0000});
    finish_ph(1'b1, '0, wrq);
    issue("t5b_d", tok, dat, bi);
    chk("t5b_d_dat", dat, {8'h4B, 64'h8000_0000_0000_0000});
    finish_ph(1'b1, '0, wrq);
    @(negedge clk);
    chk("t5b_done", {task_done, task_success}, 2'b11);

    // 6a: burst_len 0 behaves as one beat
    start_task(2'd2, 16'h00FF, 3'd0);
    wr_data = 64'h1;
    issue("t6a_a", tok, dat, bi);
    finish_ph(1'b1, '0, wrq);
    issue("t6a_d", tok, dat, bi);
    chk("t6a_d_dat", dat, {8'h4B, 64'h8000_0000_0000_0000});
    finish_ph(1'b1, '0, wrq);
    chk("t6a_last_wrreq", wrq, 1'b0);
    @(negedge clk);
    chk("t6a_done", {task_done, task_success}, 2'b11);

    // 6b: four-beat write, PID toggles, retried beat keeps its PID
    start_task(2'd2, 16'h0010, 3'd4);
    wr_data = 64'h1;
    issue("t6b_a", tok, dat, bi);
    finish_ph(1'b1, '0, wrq);
    for (int b = 0; b < 4; b++) begin
      issue("t6b_d", tok, dat, bi);
      chk("t6b_dat", dat, w4_tab[b]);
      chk("t6b_beat", bi, 3'(b));
      if (b == 1) begin
        finish_ph(1'b0, '0, wrq);
        chk("t6b_retry_wrreq", wrq, 1'b0);
        issue("t6b_rd", tok, dat, bi);
        chk("t6b_retry_dat", dat, w4_tab[1]);
        chk("t6b_retry_beat", bi, 3'd1);
      end
      wr_data = 64'(b + 2);
      finish_ph(1'b1, '0, wrq);
      chk("t6b_wrreq", wrq, b != 3);
    end
    @(negedge clk);
    chk("t6b_done", {task_done, task_success}, 2'b11);

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule
